clause_row: RTL

Parametrised clause row for the SAT engine: one clause of `NUM_LITS` literal slots, each attached to one variable's base cell. Holds literal polarities, a per-literal implied flag and the decision level of each implication. It detects satisfaction, unit and conflict conditions, drives unit implications and conflict markers back to the base cells, and undoes its own implications on a backtrack to a given level. Sits between the variable base-cell column and the clause-status/priority logic. Multi-literal generalisation of the single literal cell, with level tracking and backtrack added.

---
 rtl/clause_row.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/clause_row.sv
// One SAT clause row: NUM_LITS literal slots with unit implication, conflict
// detection and undo of its own implications on backtrack to a given level.
module clause_row #(
    parameter int NUM_LITS = 8,
    parameter int LVL_W    = 4,
    parameter int IDX_W    = $clog2(NUM_LITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_i,
    input  logic [3*NUM_LITS-1:0] var_value_frombase_i,
    output logic [3*NUM_LITS-1:0] var_value_tobase_o,
    input  logic                  imp_drv_i,
    input  logic                  cclause_drv_i,
    input  logic [LVL_W-1:0]      cur_lvl_i,
    input  logic                  bkt_i,
    input  logic [LVL_W-1:0]      bkt_lvl_i,
    output logic                  clausesat_o,
    output logic [1:0]            freelitcnt_o,
    output logic                  imp_valid_o,
    output logic [IDX_W-1:0]      imp_idx_o,
    output logic                  cclause_o,
    output logic [1:0]            state_o
);
    typedef enum logic [1:0] {
        EMPTY    = 2'b00,
        WATCH    = 2'b01,
        IMPLIED  = 2'b10,
        CONFLICT = 2'b11
    } state_t;

    state_t              state, state_nx;
    logic [1:0]          lit_r [NUM_LITS];
    logic [NUM_LITS-1:0] imp_r;
    logic [LVL_W-1:0]    lvl_r [NUM_LITS];

    logic [1:0]          value [NUM_LITS];
    logic [NUM_LITS-1:0] part, sat_v, clash;
    logic [NUM_LITS-1:0] unused_bits;
    logic                one_free, many_free, any_value;
    logic [IDX_W-1:0]    free_idx;
    logic                active, any_sat, fire, conflict;

    // Per-slot decode; free_idx is only meaningful when exactly one slot is free.
    always_comb begin
        one_free  = 1'b0;
        many_free = 1'b0;
        any_value = 1'b0;
        free_idx  = '0;
        part      = '0;
        sat_v     = '0;
        clash     = '0;
        for (int k = 0; k < NUM_LITS; k++) begin
            value[k]       = var_value_frombase_i[3*k+1 +: 2];
            unused_bits[k] = var_value_frombase_i[3*k];
            part[k]        = (lit_r[k] != 2'b00);
            sat_v[k]       = part[k] && (lit_r[k] == value[k]);
            clash[k]       = part[k] && imp_r[k] && (value[k] == 2'b11);
            if (value[k] != 2'b00)
                any_value = 1'b1;
            if (part[k] && (value[k] == 2'b00)) begin
                if (one_free)
                    many_free = 1'b1;
                one_free = 1'b1;
                free_idx = IDX_W'(k);
            end
        end
    end

    assign active   = (state != EMPTY);
    assign any_sat  = |sat_v;
    assign fire     = (state == WATCH) && imp_drv_i && !any_sat && one_free && !many_free
                      && !wr_i && !bkt_i;
    assign conflict = active && ((|clash) || ((|part) && !one_free && !any_sat)
                                 || (state == CONFLICT));

    assign clausesat_o  = active && any_sat;
    assign freelitcnt_o = !active ? 2'b00 : many_free ? 2'b11 : one_free ? 2'b01 : 2'b00;
    assign imp_valid_o  = fire;
    assign imp_idx_o    = fire ? free_idx : '0;
    assign cclause_o    = conflict;
    assign state_o      = state;

    always_comb begin
        var_value_tobase_o = '0;
        if (active) begin
            for (int k = 0; k < NUM_LITS; k++) begin
                if (fire && (free_idx == IDX_W'(k)))
                    var_value_tobase_o[3*k +: 3] = {lit_r[k], 1'b1};
                else
                    var_value_tobase_o[3*k +: 3] =
                        {(part[k] && cclause_drv_i) ? 2'b11 : 2'b00, imp_r[k]};
            end
        end
    end

    // Write beats backtrack, backtrack beats implication and conflict latch.
    always_comb begin
        state_nx = state;
        if (wr_i) begin
            state_nx = any_value ? WATCH : EMPTY;
        end else if (bkt_i) begin
            state_nx = active ? WATCH : EMPTY;
        end else begin
            if (fire)
                state_nx = IMPLIED;
            if (((state == WATCH) || (state == IMPLIED)) && conflict)
                state_nx = CONFLICT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= EMPTY;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            imp_r <= '0;
            for (int k = 0; k < NUM_LITS; k++) begin
                lit_r[k] <= 2'b00;
                lvl_r[k] <= '0;
            end
        end else if (wr_i) begin
            imp_r <= '0;
            for (int k = 0; k < NUM_LITS; k++) begin
                lit_r[k] <= value[k];
                lvl_r[k] <= '0;
            end
        end else if (bkt_i) begin
            for (int k = 0; k < NUM_LITS; k++) begin
                if (lvl_r[k] > bkt_lvl_i) begin
                    imp_r[k] <= 1'b0;
                    lvl_r[k] <= '0;
                end
            end
        end else if (fire) begin
            imp_r[free_idx] <= 1'b1;
            lvl_r[free_idx] <= cur_lvl_i;
        end
    end
endmodule
